muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide execute unit that consumes the two register-file read operands (`rd1`/`rd2`) in the execute stage and returns a result plus destination register tag for writeback. One operation is in flight at a time. Shift-add multiply and restoring divide run over XLEN cycles. RISC-V special cases (divide by zero, signed overflow) bypass the iteration. The pipeline stalls on `busy` and writes `result` to `rd_out` on the `done` pulse.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals XLEN.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand (register-file `rd1`).
- `b`  in  XLEN  rs2 operand (register-file `rd2`).
- `rd_in`  in  5  destination tag, captured with the operands.
- `kill`  in  1  pipeline flush; aborts the in-flight operation.
- `busy`  out  1  operation in progress; the pipeline stalls.
- `done`  out  1  single-cycle pulse; `result`/`rd_out` valid.
- `result`  out  XLEN  operation result.
- `rd_out`  out  5  destination tag matching `result`.
- `illegal`  out  1  qualifies `done`; the op was unsupported in this build.

## Operation
- FSM states: IDLE, PREP, CALC, FIN.
- IDLE:
  - `start`=1 → capture `op`/`a`/`b`/`rd_in`, go to PREP, `busy`=1.
- PREP:
  - Record result sign and take operand magnitudes. MULH: both signed. MULHSU: `a` signed only. MULHU/DIVU/REMU: unsigned.
  - Detect special cases: divide by zero, or DIV/REM with `a`=0x80000000 and `b`=0xFFFFFFFF. Special case → FIN; otherwise → CALC with the counter cleared.
- CALC:
  - One shift-add (mul) or one restore-subtract (div) step per cycle, into a 2·XLEN accumulator.
  - Counter 0..XLEN-1; at XLEN-1 → FIN.
- FIN:
  - Apply sign fix (two's complement negate of the 2·XLEN product, quotient or remainder).
  - Select: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
  - Register `result`/`rd_out`, pulse `done`, go to IDLE, `busy`=0.
- Special-case results:
  - DIV/DIVU by 0 → 0xFFFFFFFF.
  - REM/REMU by 0 → `a`.
  - Overflow DIV → 0x80000000; overflow REM → 0.
- Remainder takes the sign of the dividend.
- `start` while `busy`=1 is ignored and not queued.
- `kill`=1 in any non-IDLE state → IDLE next edge, `busy`=0, no `done`. `kill` wins over FIN completion. `kill` in IDLE with `start`=1 → request dropped.
- `result`/`rd_out` hold their value until the next `done`.

## Timing
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `illegal`=0.
  - `result`=0, `rd_out`=0; counter and accumulator 0.
- Reset asserted mid-operation: immediate return to reset values; no `done`.
- Start sampled at edge 0 → `busy` high after edge 0.
  - Normal op: `done` high after edge XLEN+2 (34 for XLEN=32), exactly one cycle.
  - Special case: `done` after edge 2.
- `busy` falls on the same edge `done` rises.
- Back-to-back: a `start` in the `done` cycle is accepted.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU/REM/REMU fully implemented; `illegal` always 0.
- Not defined: divide datapath and special-case logic are omitted.
  - Ops 1xx take the special-case path; `done` after edge 2 with `result`=0 and `illegal`=1.
  - MUL* timing is unchanged.

## Structure
- Shared package `muldiv_pkg`:
  - `XLEN` default.
  - funct3 op encodings as named constants.
  - FSM state enum.
  - Special-case constants (0x80000000, all-ones).
- Single module, no sub-module: the shared accumulator/counter datapath is simpler inline.

## Test plan
- MUL `a`=7, `b`=0xFFFFFFFD (−3), `rd_in`=5 → `done` at edge 34, `result`=0xFFFFFFEB, `rd_out`=5, `busy` high edges 0–33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 0x1234/0 → 0xFFFFFFFF, `done` at edge 2. REMU 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- `start` re-pulsed at edge 5 with different operands → ignored, first result intact. `kill` at edge 10 → `busy`=0 at edge 11, no `done`. `rst` pulsed at edge 20 → all outputs 0.
- Build without `MULDIV_DIV_EN`: DIV 10/2 → `done` at edge 2, `result`=0, `illegal`=1. Then MUL 3×4 → 12, `illegal`=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M iterative multiply/divide unit:
// datapath width, funct3 encodings, FSM state codes and special-case values.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PREP = 2'd1;
  localparam state_t ST_CALC = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

  localparam logic [XLEN_DEF-1:0] MIN_NEG  = {1'b1, {(XLEN_DEF-1){1'b0}}};
  localparam logic [XLEN_DEF-1:0] ALL_ONES = {XLEN_DEF{1'b1}};

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit: shift-add multiply and restoring divide.
// Divide support is compiled in only when MULDIV_DIV_EN is defined; otherwise 1xx ops flag illegal.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN);

  state_t            state;
  logic [2:0]        op_r;
  logic [4:0]        rd_r;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;
  logic              q_neg;
  logic              special;
  logic              ill;
`ifdef MULDIV_DIV_EN
  logic              r_neg;
`endif

  // Raw operands sit in opnd (rs1) and the low accumulator word (rs2) between capture and PREP.
  logic [XLEN-1:0] ra, rb, mag_a, mag_b;
  logic            sa, sb, is_div;

  assign ra     = opnd;
  assign rb     = acc[XLEN-1:0];
  assign is_div = op_r[2];
  assign busy   = (state != ST_IDLE);

  always_comb begin
    sa    = ((op_r == OP_MULH) || (op_r == OP_MULHSU) || (op_r == OP_DIV) || (op_r == OP_REM))
            && ra[XLEN-1];
    sb    = ((op_r == OP_MULH) || (op_r == OP_DIV) || (op_r == OP_REM)) && rb[XLEN-1];
    mag_a = sa ? -ra : ra;
    mag_b = sb ? -rb : rb;
  end

  logic            spec_hit;
  logic            spec_ill;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    spec_hit = 1'b0;
    spec_ill = 1'b0;
    spec_val = '0;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      if (rb == '0) begin
        spec_hit = 1'b1;
        spec_val = op_r[1] ? ra : ALL_ONES;
      end else if (!op_r[0] && (ra == MIN_NEG) && (rb == ALL_ONES)) begin
        spec_hit = 1'b1;
        spec_val = op_r[1] ? '0 : MIN_NEG;
      end
    end
`else
    if (is_div) begin
      spec_hit = 1'b1;
      spec_ill = 1'b1;
    end
`endif
  end

  // Multiply: multiplier shifts out of the low word while partial sums enter from the top.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] step_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // Divide: partial remainder is taken one bit wider so a top-bit-set remainder is not lost.
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    div_diff  = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    div_next  = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    step_next = is_div ? div_next : mul_next;
  end
`else
  assign step_next = mul_next;
`endif

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin_val;

  always_comb begin
    prod    = q_neg ? -acc : acc;
    fin_val = prod[XLEN-1:0];
    if (special) begin
      fin_val = acc[XLEN-1:0];
    end else begin
      case (op_r)
        OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        OP_DIV, OP_DIVU: fin_val = q_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        OP_REM, OP_REMU: fin_val = r_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
`endif
        default:         fin_val = prod[XLEN-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_r    <= '0;
      rd_r    <= '0;
      opnd    <= '0;
      acc     <= '0;
      count   <= '0;
      q_neg   <= 1'b0;
      special <= 1'b0;
      ill     <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg   <= 1'b0;
`endif
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      // A flush beats everything, including a completion or a new request in IDLE.
      if (kill) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_r  <= op;
              rd_r  <= rd_in;
              opnd  <= a;
              acc   <= {{XLEN{1'b0}}, b};
              state <= ST_PREP;
            end
          end
          ST_PREP: begin
            if (spec_hit) begin
              acc     <= {{XLEN{1'b0}}, spec_val};
              special <= 1'b1;
              ill     <= spec_ill;
              state   <= ST_FIN;
            end else begin
              special <= 1'b0;
              ill     <= 1'b0;
              q_neg   <= sa ^ sb;
              count   <= '0;
              state   <= ST_CALC;
`ifdef MULDIV_DIV_EN
              r_neg   <= sa;
              if (is_div) begin
                opnd <= mag_b;
                acc  <= {{XLEN{1'b0}}, mag_a};
              end else begin
                opnd <= mag_a;
                acc  <= {{XLEN{1'b0}}, mag_b};
              end
`else
              opnd    <= mag_a;
              acc     <= {{XLEN{1'b0}}, mag_b};
`endif
            end
          end
          ST_CALC: begin
            acc   <= step_next;
            count <= count + 1'b1;
            if (count == CW'(XLEN - 1)) state <= ST_FIN;
          end
          ST_FIN: begin
            result  <= fin_val;
            rd_out  <= rd_r;
            illegal <= ill;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
